// File: rtl/sample_stream_out.sv
// Output stage for filter samples: offset-binary to two's-complement conversion, a start-of-run
// discard window, and a first-word-fall-through FIFO with sticky drop statistics.
module sample_stream_out #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 8,
    parameter int SKIP  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in,
    input  logic                     in_stb,
    input  logic                     filt_valid,
    input  logic                     clr,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_RUN
    } state_t;

    state_t           state_reg;
    logic [7:0]       skip_cnt_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic             overflow_reg;
    logic [7:0]       drop_cnt_reg;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             accept;
    logic             push_req;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic             skip_last;
    logic [WIDTH-1:0] conv_word;

    // Offset binary becomes two's complement by inverting the sign bit only.
    assign conv_word = {~in[WIDTH-1], in[WIDTH-2:0]};

    assign accept    = in_stb & filt_valid;
    assign push_req  = accept & (state_reg == ST_RUN);
    assign level     = wr_ptr_reg - rd_ptr_reg;
    assign out_valid = (level != '0);
    assign full      = (level == PW'(DEPTH));
    assign pop       = out_valid & out_ready;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign push      = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;
    assign skip_last = (({1'b0, skip_cnt_reg} + 9'd1) == 9'(SKIP));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            skip_cnt_reg <= 8'd0;
        end else if (!filt_valid) begin
            state_reg    <= ST_IDLE;
            skip_cnt_reg <= 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_reg    <= (SKIP > 0) ? ST_SKIP : ST_RUN;
                    skip_cnt_reg <= 8'd0;
                end
                ST_SKIP: begin
                    if (accept) begin
                        if (skip_last) begin
                            state_reg    <= ST_RUN;
                            skip_cnt_reg <= 8'd0;
                        end else begin
                            skip_cnt_reg <= skip_cnt_reg + 8'd1;
                        end
                    end
                end
                ST_RUN: begin
                    state_reg <= ST_RUN;
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    skip_cnt_reg <= 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= conv_word;
        end
    end

    assign out_data = mem[rd_ptr_reg[AW-1:0]];

    // clr takes priority over a coincident drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= 8'd0;
        end else if (clr) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= 8'd0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
            if (drop_cnt_reg != 8'hFF) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    assign overflow = overflow_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_sample_stream_out.sv
// Bench for sample_stream_out: fixed vector table, directed corner sequences and a randomized
// run, all compared against a queue-based reference model.
module tb_sample_stream_out;

    localparam int WIDTH = 14;
    localparam int DEPTH = 8;
    localparam int SKIP  = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             in_stb;
    logic             filt_valid;
    logic             clr;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [LW-1:0]    level;
    logic             overflow;
    logic [7:0]       drop_cnt;

    sample_stream_out #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SKIP(SKIP)) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (din),
        .in_stb     (in_stb),
        .filt_valid (filt_valid),
        .clr        (clr),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of expected words plus run bookkeeping.
    int mq[$];
    int m_phase;      // 0 waiting for filt_valid, 1 discarding, 2 storing
    int m_skipped;
    int m_ov;
    int m_cnt;

    typedef struct {
        bit fv;
        bit stb;
        bit rdy;
        bit clr;
        int din;
        bit exp_valid;
        int exp_data;
        int exp_level;
    } vec_t;

    vec_t tbl[12];

    function automatic int conv_ref(int v);
        return (v - (1 << (WIDTH - 1))) & ((1 << WIDTH) - 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_phase   = 0;
        m_skipped = 0;
        m_ov      = 0;
        m_cnt     = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "/valid"}, int'(out_valid), (mq.size() != 0) ? 1 : 0);
        check({tag, "/level"}, int'(level), mq.size());
        if (mq.size() != 0) check({tag, "/data"}, int'(out_data), mq[0]);
        check({tag, "/overflow"}, int'(overflow), m_ov);
        check({tag, "/drop_cnt"}, int'(drop_cnt), m_cnt);
    endtask

    // Advance one clock: update the model from the inputs now applied, then compare after the edge.
    task automatic step(input string tag);
        bit pop, acc, push, drop;
        pop  = (mq.size() != 0) && out_ready;
        acc  = in_stb && filt_valid;
        push = 1'b0;
        if (!filt_valid) begin
            m_phase   = 0;
            m_skipped = 0;
        end else if (m_phase == 0) begin
            m_phase = (SKIP > 0) ? 1 : 2;
        end else if (m_phase == 1) begin
            if (acc) begin
                m_skipped++;
                if (m_skipped == SKIP) begin
                    m_phase   = 2;
                    m_skipped = 0;
                end
            end
        end else if (acc) begin
            push = 1'b1;
        end
        drop = push && (mq.size() == DEPTH) && !pop;
        if (pop) void'(mq.pop_front());
        if (push && !drop) mq.push_back(conv_ref(int'(din)));
        if (clr) begin
            m_ov  = 0;
            m_cnt = 0;
        end else if (drop) begin
            m_ov = 1;
            if (m_cnt < 255) m_cnt++;
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic drive(input bit fv, input bit stb, input bit rdy, input bit c, input int d);
        filt_valid = fv;
        in_stb     = stb;
        out_ready  = rdy;
        clr        = c;
        din        = WIDTH'(d);
    endtask

    initial begin
        // fv stb rdy clr din      valid data    level
        tbl[0]  = '{1, 0, 0, 0, 'h0000, 0, 0,      0};
        tbl[1]  = '{1, 1, 0, 0, 'h2000, 0, 0,      0};
        tbl[2]  = '{1, 1, 0, 0, 'h2001, 0, 0,      0};
        tbl[3]  = '{1, 1, 0, 0, 'h2002, 0, 0,      0};
        tbl[4]  = '{1, 1, 0, 0, 'h2003, 0, 0,      0};
        tbl[5]  = '{1, 1, 0, 0, 'h2004, 1, 'h0004, 1};
        tbl[6]  = '{1, 1, 0, 0, 'h2005, 1, 'h0004, 2};
        tbl[7]  = '{1, 0, 1, 0, 'h0000, 1, 'h0005, 1};
        tbl[8]  = '{1, 0, 1, 0, 'h0000, 0, 0,      0};
        tbl[9]  = '{1, 1, 0, 0, 'h0000, 1, 'h2000, 1};
        tbl[10] = '{1, 1, 1, 0, 'h3FFF, 1, 'h1FFF, 1};
        tbl[11] = '{1, 0, 1, 0, 'h0000, 0, 0,      0};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Discard window, conversion and first-word latency
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].fv, tbl[i].stb, tbl[i].rdy, tbl[i].clr, tbl[i].din);
            step("vec");
            check($sformatf("vec%0d/valid", i), int'(out_valid), int'(tbl[i].exp_valid));
            check($sformatf("vec%0d/level", i), int'(level), tbl[i].exp_level);
            if (tbl[i].exp_valid) check($sformatf("vec%0d/data", i), int'(out_data), tbl[i].exp_data);
            check($sformatf("vec%0d/overflow", i), int'(overflow), 0);
        end

        // Backpressure: 12 pushes into an 8-deep FIFO, then drain in order
        for (int i = 0; i < 12; i++) begin
            drive(1, 1, 0, 0, 'h0100 + i);
            step("bp_fill");
        end
        check("bp/level", int'(level), 8);
        check("bp/overflow", int'(overflow), 1);
        check("bp/drop_cnt", int'(drop_cnt), 4);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bp/drain%0d", i), int'(out_data), conv_ref('h0100 + i));
            drive(1, 0, 1, 0, 0);
            step("bp_drain");
        end
        check("bp/empty", int'(out_valid), 0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, 0, 'h0200 + i);
            step("pp_fill");
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, 0, 'h0300 + i);
            step("pp");
            check("pp/level", int'(level), 8);
            check("pp/drop_cnt", int'(drop_cnt), 4);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 1, 0, 0);
            step("pp_drain");
        end

        // filt_valid loss with words queued, then a fresh discard window
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 'h0400 + i);
            step("fv_fill");
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 'h0500 + i);
            step("fv_ign");
        end
        check("fv/level", int'(level), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("fv/word%0d", i), int'(out_data), conv_ref('h0400 + i));
            drive(0, 0, 1, 0, 0);
            step("fv_drain");
        end
        drive(1, 0, 1, 0, 0);
        step("fv_rise");
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1, 0, 'h0600 + i);
            step("fv_skip");
            check("fv/skip_level", int'(level), 0);
        end
        drive(1, 1, 0, 0, 'h0700);
        step("fv_run");
        check("fv/run_level", int'(level), 1);
        check("fv/run_data", int'(out_data), conv_ref('h0700));

        // Drop counter saturation and clr against a coincident drop
        for (int i = 0; i < 300; i++) begin
            drive(1, 1, 0, 0, i);
            step("sat");
        end
        check("sat/drop_cnt", int'(drop_cnt), 255);
        check("sat/overflow", int'(overflow), 1);
        drive(1, 1, 0, 1, 'h0123);
        step("clr_drop");
        check("clr/overflow", int'(overflow), 0);
        check("clr/drop_cnt", int'(drop_cnt), 0);
        drive(1, 1, 0, 0, 'h0124);
        step("post_clr");
        check("post_clr/drop_cnt", int'(drop_cnt), 1);

        // Asynchronous reset between edges with 5 words queued
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 0, 0);
            step("ar_drain");
        end
        check("ar/level_before", int'(level), 5);
        drive(1, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("ar/valid", int'(out_valid), 0);
        check("ar/level", int'(level), 0);
        check("ar/overflow", int'(overflow), 0);
        check("ar/drop_cnt", int'(drop_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 'h0800 + i);
            step("ar_nofv");
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, 'h0900 + i);
            step("ar_skip");
            check("ar/skip_level", int'(level), 0);
        end
        drive(1, 1, 0, 0, 'h0A00);
        step("ar_run");
        check("ar/run_level", int'(level), 1);

        // Randomized traffic with bursty backpressure
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 39) != 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  (((i / 64) % 2) == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                  int'($urandom_range(0, (1 << WIDTH) - 1)));
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
